// File: rtl/gate_mac_sequencer.sv
// Gate pre-activation MAC sequencer: sum(W[i]*X[i]) + b over one shared multiplier.
// Ports: clk/rst, start/len/bias command, rd_en/rd_addr/x_data/w_data memory, busy, out_valid/out_ready/out_data result.
module gate_mac_sequencer #(
   parameter int DATA_WIDTH  = 16,
   parameter int FRACT_WIDTH = 8,
   parameter int ADDR_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic [DATA_WIDTH-1:0] bias,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] x_data,
   input  logic [DATA_WIDTH-1:0] w_data,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam int PW = 2*DATA_WIDTH;
   localparam int AW = 2*DATA_WIDTH + ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_RUN, S_DRAIN, S_FINISH, S_OUT
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [DATA_WIDTH-1:0] bias_q, bias_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AW-1:0]         acc_q, acc_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic                  vld_q;

   logic signed [PW-1:0]  prod_full;
   logic signed [PW-1:0]  prod_sh;
   logic [AW-1:0]         prod_ext;
   logic [AW-1:0]         sum;
   logic [AW-DATA_WIDTH:0] sum_hi;
   logic                  last;

   assign prod_full = $signed(x_data) * $signed(w_data);
   assign prod_sh   = prod_full >>> FRACT_WIDTH;
   assign prod_ext  = {{ADDR_WIDTH{prod_sh[PW-1]}}, prod_sh};
   assign sum       = acc_q + {{(AW-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
   // Result fits iff all bits from the result sign bit upward agree.
   assign sum_hi    = sum[AW-1:DATA_WIDTH-1];
   assign last      = ({1'b0, addr_q} == len_q - (ADDR_WIDTH+1)'(1));

   assign rd_en     = (state_q == S_RUN);
   assign rd_addr   = addr_q;
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_OUT);
   assign out_data  = out_q;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      bias_d  = bias_q;
      addr_d  = '0;
      acc_d   = acc_q;
      out_d   = out_q;
      if (vld_q) acc_d = acc_q + prod_ext;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = (len > MAX_LEN) ? MAX_LEN : len;
               bias_d  = bias;
               acc_d   = '0;
               state_d = (len == '0) ? S_FINISH : S_RUN;
            end
         end
         S_RUN: begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (last) begin
               addr_d  = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: state_d = S_FINISH;
         S_FINISH: begin
            if ((sum_hi == '0) || (sum_hi == '1))
               out_d = sum[DATA_WIDTH-1:0];
            else if (sum[AW-1])
               out_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            else
               out_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            state_d = S_OUT;
         end
         S_OUT: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         bias_q  <= '0;
         addr_q  <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         bias_q  <= bias_d;
         addr_q  <= addr_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         vld_q   <= rd_en;
      end
   end

endmodule

// File: tb/tb_gate_mac_sequencer.sv
// Testbench for gate_mac_sequencer: randomized and directed jobs against a
// behavioural dot-product model, with latency, read-sequence and handshake checks.
module tb_gate_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [6:0]  len = '0;
   logic [15:0] bias = '0;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic [15:0] x_data = '0;
   logic [15:0] w_data = '0;
   logic        busy;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;

   int tests = 0;
   int fails = 0;

   logic [15:0] x_mem [64];
   logic [15:0] w_mem [64];
   int          rd_log [$];

   gate_mac_sequencer #(
      .DATA_WIDTH(16), .FRACT_WIDTH(8), .ADDR_WIDTH(6)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
      .rd_en(rd_en), .rd_addr(rd_addr), .x_data(x_data), .w_data(w_data),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data)
   );

   always #5 clk = ~clk;

   // Memories answer one cycle after rd_en; junk is driven otherwise.
   always @(posedge clk) begin
      if (rd_en) begin
         rd_log.push_back(int'(rd_addr));
         x_data <= x_mem[rd_addr];
         w_data <= w_mem[rd_addr];
      end else begin
         x_data <= 16'($urandom);
         w_data <= 16'($urandom);
      end
   end

   function automatic logic [15:0] model(input int l, input logic [15:0] b);
      longint acc = 0;
      longint p;
      int n = (l > 64) ? 64 : l;
      for (int i = 0; i < n; i++) begin
         p = longint'($signed(x_mem[i])) * longint'($signed(w_mem[i]));
         acc += (p >>> 8);
      end
      acc += longint'($signed(b));
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      return 16'(acc);
   endfunction

   task automatic do_job(input int l, input logic [15:0] b,
                         output logic [15:0] res, output int lat);
      rd_log.delete();
      start = 1'b1;
      len   = 7'(l);
      bias  = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!out_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      res = out_data;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({rd_en, rd_addr, busy, out_valid, out_data} !== 25'd0) begin
         fails++;
         $display("FAIL reset: rd_en=%b addr=%0d busy=%b valid=%b data=%h want all 0",
                  rd_en, rd_addr, busy, out_valid, out_data);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [15:0] r;
      int lat;
      x_mem[0] = 16'h0100; w_mem[0] = 16'h0080;
      x_mem[1] = 16'h0200; w_mem[1] = 16'h0040;
      x_mem[2] = 16'hFF80; w_mem[2] = 16'h0400;
      do_job(3, 16'h0040, r, lat);
      tests++;
      if (r !== 16'hFF40) begin
         fails++;
         $display("FAIL basic_data: got %h want ff40", r);
      end
      tests++;
      if (lat != 6) begin
         fails++;
         $display("FAIL basic_latency: got %0d want 6", lat);
      end
      tests++;
      if (rd_log.size() != 3 || rd_log[0] != 0 || rd_log[1] != 1 ||
          rd_log[2] != 2) begin
         fails++;
         $display("FAIL basic_addrs: got %p want 0,1,2", rd_log);
      end
      tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_idle: busy=%b valid=%b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_saturation();
      logic [15:0] r;
      int lat;
      for (int i = 0; i < 4; i++) begin
         x_mem[i] = 16'h7F00; w_mem[i] = 16'h0200;
      end
      do_job(4, 16'h0000, r, lat);
      tests++;
      if (r !== 16'h7FFF) begin
         fails++;
         $display("FAIL sat_pos: got %h want 7fff", r);
      end
      for (int i = 0; i < 4; i++) w_mem[i] = 16'hFE00;
      do_job(4, 16'h0000, r, lat);
      tests++;
      if (r !== 16'h8000) begin
         fails++;
         $display("FAIL sat_neg: got %h want 8000", r);
      end
      w_mem[0] = 16'h0200; w_mem[1] = 16'hFE00;
      do_job(2, 16'h0010, r, lat);
      tests++;
      if (r !== 16'h0010) begin
         fails++;
         $display("FAIL sat_cancel: got %h want 0010", r);
      end
   endtask

   task automatic test_rounding();
      logic [15:0] r;
      int lat;
      x_mem[0] = 16'h0001; w_mem[0] = 16'h0001;
      x_mem[1] = 16'hFFFF; w_mem[1] = 16'h0001;
      do_job(2, 16'h0000, r, lat);
      tests++;
      if (r !== 16'hFFFF) begin
         fails++;
         $display("FAIL rounding: got %h want ffff", r);
      end
   endtask

   task automatic test_zero_len();
      logic [15:0] r;
      int lat;
      do_job(0, 16'h0123, r, lat);
      tests++;
      if (r !== 16'h0123 || lat != 2 || rd_log.size() != 0) begin
         fails++;
         $display("FAIL zero_len: data=%h lat=%0d reads=%0d want 0123 2 0",
                  r, lat, rd_log.size());
      end
   endtask

   task automatic test_clamp();
      logic [15:0] r;
      int lat;
      int bad = 0;
      for (int i = 0; i < 64; i++) begin
         x_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
         w_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
      end
      do_job(69, 16'h0005, r, lat);
      for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] != i) bad++;
      tests++;
      if (rd_log.size() != 64 || bad != 0 || lat != 67) begin
         fails++;
         $display("FAIL clamp_reads: reads=%0d badaddr=%0d lat=%0d want 64 0 67",
                  rd_log.size(), bad, lat);
      end
      tests++;
      if (r !== model(69, 16'h0005)) begin
         fails++;
         $display("FAIL clamp_data: got %h want %h", r, model(69, 16'h0005));
      end
   endtask

   task automatic test_random();
      logic [15:0] r, b, exp;
      int lat, l, n;
      for (int it = 0; it < 16; it++) begin
         l = $urandom_range(0, 80);
         b = 16'($urandom);
         for (int i = 0; i < 64; i++) begin
            if (it % 2 == 0) begin
               x_mem[i] = 16'($urandom);
               w_mem[i] = 16'($urandom);
            end else begin
               x_mem[i] = 16'($urandom_range(0, 511)) - 16'd256;
               w_mem[i] = 16'($urandom_range(0, 511)) - 16'd256;
            end
         end
         exp = model(l, b);
         n = (l > 64) ? 64 : l;
         do_job(l, b, r, lat);
         tests++;
         if (r !== exp || lat != ((n == 0) ? 2 : n + 3) ||
             rd_log.size() != n || busy !== 1'b0) begin
            fails++;
            $display("FAIL random[%0d] L=%0d: data=%h lat=%0d reads=%0d busy=%b want %h %0d %0d 0",
                     it, l, r, lat, rd_log.size(), busy, exp,
                     (n == 0) ? 2 : n + 3, n);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] held, r;
      int lat;
      int bad = 0;
      x_mem[0] = 16'h0300; w_mem[0] = 16'h0100;
      out_ready = 1'b0;
      rd_log.delete();
      start = 1'b1; len = 7'd1; bias = 16'h0001;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      held = out_data;
      rd_log.delete();
      tests++;
      if (held !== 16'h0301 || lat != 4) begin
         fails++;
         $display("FAIL bp_result: data=%h lat=%0d want 0301 4", held, lat);
      end
      for (int c = 0; c < 5; c++) begin
         start = c[0] ? 1'b0 : 1'b1;
         len = 7'd3;
         @(posedge clk); #1;
         if (out_data !== held || busy !== 1'b1 || out_valid !== 1'b1) bad++;
      end
      start = 1'b0;
      tests++;
      if (bad != 0 || rd_log.size() != 0) begin
         fails++;
         $display("FAIL bp_hold: unstable=%0d reads=%0d want 0 0", bad, rd_log.size());
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL bp_release: valid=%b busy=%b want 0 0", out_valid, busy);
      end
      x_mem[0] = 16'h0100; w_mem[0] = 16'h0200;
      do_job(1, 16'h0000, r, lat);
      tests++;
      if (r !== 16'h0200 || lat != 4) begin
         fails++;
         $display("FAIL bp_next: data=%h lat=%0d want 0200 4", r, lat);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] r;
      int lat;
      for (int i = 0; i < 8; i++) begin
         x_mem[i] = 16'h4000; w_mem[i] = 16'h4000;
      end
      start = 1'b1; len = 7'd8; bias = 16'h1111;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({rd_en, rd_addr, busy, out_valid, out_data} !== 25'd0) begin
         fails++;
         $display("FAIL midreset: rd_en=%b addr=%0d busy=%b valid=%b data=%h want all 0",
                  rd_en, rd_addr, busy, out_valid, out_data);
      end
      rst = 1'b0;
      x_mem[0] = 16'h0100; w_mem[0] = 16'h0100;
      do_job(1, 16'h0000, r, lat);
      tests++;
      if (r !== 16'h0100 || lat != 4) begin
         fails++;
         $display("FAIL midreset_next: data=%h lat=%0d want 0100 4", r, lat);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         x_mem[i] = '0;
         w_mem[i] = '0;
      end
      test_reset();
      test_basic();
      test_saturation();
      test_rounding();
      test_zero_len();
      test_clamp();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
